// File: rtl/serial_negate_seq.sv
// Word-level sequencer for a bit-serial two's-complement negator.
// Accepts a parallel word, streams it LSB-first to an external serial unit,
// reassembles the serial result and presents it over a valid/ready handshake.
// Optional self-check against a parallel reference: define SERIAL_NEG_CHECK_EN.
module serial_negate_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SER_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err,
  output logic             ser_clr_n,
  output logic             ser_data,
  input  logic             ser_out
);

  localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StShift, StDrain, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_res;
  logic [CntW-1:0]  r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_capture;
  logic             w_enter_done;
  logic             w_err;
  logic [WIDTH-1:0] w_res_d;

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_last   = (r_state == StShift) && (r_cnt == CntLast);
  assign w_res_d  = {ser_out, r_res[WIDTH-1:1]};

  // With a registered serial unit the first SHIFT edge has nothing valid yet;
  // the DRAIN edge picks up the final bit instead.
  assign w_capture = (SER_LAT == 0) ? (r_state == StShift)
                                    : (((r_state == StShift) && (r_cnt != '0)) ||
                                       (r_state == StDrain));
  assign w_enter_done = (SER_LAT == 0) ? w_last : (r_state == StDrain);

  // Control FSM, input shift register, bit counter and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_shreg <= in_data;
            r_cnt   <= '0;
            r_ovf   <= (in_data == MostNeg);
            r_state <= StShift;
          end
        end
        StShift: begin
          r_shreg <= r_shreg >> 1;
          r_cnt   <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) begin
            if (SER_LAT == 0) r_state <= StDone;
            else              r_state <= StDrain;
          end
        end
        StDrain: begin
          r_state <= StDone;
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Result reassembly: serial bits enter at the MSB and walk down to bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res <= '0;
    end else if (w_capture) begin
      r_res <= w_res_d;
    end
  end

`ifdef SERIAL_NEG_CHECK_EN
  logic [WIDTH-1:0] r_ref;
  logic             r_err;

  // Parallel reference captured at accept; compared with the final result on DONE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_ref <= ~in_data + WIDTH'(1);
      r_err <= 1'b0;
    end else if (w_enter_done) begin
      r_err <= (w_res_d != r_ref);
    end
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  // Outputs decoded from the state register so ser_clr_n is glitch-free per state.
  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    out_data  = r_res;
    out_ovf   = r_ovf;
    out_err   = w_err;
    ser_clr_n = (r_state == StShift) || (r_state == StDrain);
    ser_data  = (r_state == StShift) && r_shreg[0];
  end

endmodule

// File: tb/tb_serial_negate_seq.sv
// Self-checking bench: two sequencers (SER_LAT = 0 and 1) driven in lockstep,
// each paired with a behavioural bit-serial negator model.
module tb_serial_negate_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       inj = 1'b0;

  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] out_ovf;
  logic [1:0] out_err;
  logic [1:0] ser_clr_n;
  logic [1:0] ser_data;
  logic [1:0] ser_out;
  logic [7:0] out_data [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       seen;
    logic       rout;
    logic [3:0] mcnt;
    logic       w_comb;

    serial_negate_seq #(
      .WIDTH  (8),
      .SER_LAT(g)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .in_data  (in_data),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .out_data (out_data[g]),
      .out_ovf  (out_ovf[g]),
      .out_err  (out_err[g]),
      .ser_clr_n(ser_clr_n[g]),
      .ser_data (ser_data[g]),
      .ser_out  (ser_out[g])
    );

    // Mealy negator: pass bits through the first 1, invert after; inj flips bit 2.
    assign w_comb = ser_data[g] ^ seen ^ (inj && (mcnt == 4'd2));

    always_ff @(posedge clk or negedge ser_clr_n[g]) begin
      if (!ser_clr_n[g]) begin
        seen <= 1'b0;
        rout <= 1'b0;
        mcnt <= 4'd0;
      end else begin
        seen <= seen | ser_data[g];
        rout <= w_comb;
        mcnt <= mcnt + 4'd1;
      end
    end

    assign ser_out[g] = (g == 0) ? w_comb : rout;
  end

  // Present one word for a single edge; both DUTs are expected idle.
  task automatic accept_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from accept edge until out_valid is seen; 0 means it never rose.
  task automatic wait_done(output int lat0, output int lat1);
    lat0 = 0;
    lat1 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid[0] && lat0 == 0) lat0 = c;
      if (out_valid[1] && lat1 == 0) lat1 = c;
      if (lat0 != 0 && lat1 != 0) break;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready k=%0d got=%b exp=1", k, in_ready[k]);
      end
      checks++;
      if (out_valid[k] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid k=%0d got=%b exp=0", k, out_valid[k]);
      end
      checks++;
      if (ser_clr_n[k] !== 1'b0) begin
        errors++; $display("FAIL reset_ser_clr_n k=%0d got=%b exp=0", k, ser_clr_n[k]);
      end
      checks++;
      if ({out_ovf[k], out_err[k], out_data[k]} !== 10'h000) begin
        errors++; $display("FAIL reset_outputs k=%0d got=%b%b_%h exp=00_00", k, out_ovf[k],
                           out_err[k], out_data[k]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] d, e;
    logic       o;
    int         l0, l1, lat;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin d = 8'h06; e = 8'hFA; o = 1'b0; end
        1:       begin d = 8'h80; e = 8'h80; o = 1'b1; end
        2:       begin d = 8'hFF; e = 8'h01; o = 1'b0; end
        default: begin d = 8'h7F; e = 8'h81; o = 1'b0; end
      endcase
      accept_word(d);
      wait_done(l0, l1);
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? l0 : l1;
        checks++;
        if (lat !== 8 + k) begin
          errors++; $display("FAIL basic_latency d=%h k=%0d got=%0d exp=%0d", d, k, lat, 8 + k);
        end
        checks++;
        if (out_data[k] !== e) begin
          errors++; $display("FAIL basic_data d=%h k=%0d got=%h exp=%h", d, k, out_data[k], e);
        end
        checks++;
        if (out_ovf[k] !== o || out_err[k] !== 1'b0) begin
          errors++; $display("FAIL basic_flags d=%h k=%0d got ovf=%b err=%b exp ovf=%b err=0",
                             d, k, out_ovf[k], out_err[k], o);
        end
        checks++;
        if (ser_clr_n[k] !== 1'b0 || ser_data[k] !== 1'b0 || in_ready[k] !== 1'b0) begin
          errors++; $display("FAIL basic_done_ctrl d=%h k=%0d got clr_n=%b sd=%b rdy=%b exp 0/0/0",
                             d, k, ser_clr_n[k], ser_data[k], in_ready[k]);
        end
      end
      release_out();
      checks++;
      if (in_ready !== 2'b11 || out_valid !== 2'b00) begin
        errors++; $display("FAIL basic_idle d=%h got rdy=%b vld=%b exp 11/00", d, in_ready,
                           out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int l0, l1;
    accept_word(8'h00);
    checks++;
    if (ser_clr_n !== 2'b11) begin
      errors++; $display("FAIL b2b_clr_n_shift got=%b exp=11", ser_clr_n);
    end
    wait_done(l0, l1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_data[k] !== 8'h00 || out_ovf[k] !== 1'b0) begin
        errors++; $display("FAIL b2b_zero k=%0d got=%h ovf=%b exp=00 ovf=0", k, out_data[k],
                           out_ovf[k]);
      end
    end
    release_out();
    checks++;
    if (ser_clr_n !== 2'b00) begin
      errors++; $display("FAIL b2b_clr_n_between got=%b exp=00", ser_clr_n);
    end
    accept_word(8'h01);
    wait_done(l0, l1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_data[k] !== 8'hFF || out_ovf[k] !== 1'b0) begin
        errors++; $display("FAIL b2b_one k=%0d got=%h ovf=%b exp=ff ovf=0", k, out_data[k],
                           out_ovf[k]);
      end
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int l0, l1;
    accept_word(8'h3C);
    wait_done(l0, l1);
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 2'b11 || in_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold c=%0d got vld=%b rdy=%b exp 11/00", c, out_valid,
                           in_ready);
      end
      checks++;
      if (out_data[0] !== 8'hC4 || out_data[1] !== 8'hC4) begin
        errors++; $display("FAIL bp_data c=%0d got=%h/%h exp=c4", c, out_data[0], out_data[1]);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 2'b11 || out_valid !== 2'b00) begin
      errors++; $display("FAIL bp_after_handshake got rdy=%b vld=%b exp 11/00", in_ready,
                         out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 2'b00) begin
      errors++; $display("FAIL bp_second_accept got rdy=%b exp=00", in_ready);
    end
    wait_done(l0, l1);
    checks++;
    if (l0 !== 8 || l1 !== 9) begin
      errors++; $display("FAIL bp_second_latency got=%0d/%0d exp=8/9", l0, l1);
    end
    checks++;
    if (out_data[0] !== 8'hEF || out_data[1] !== 8'hEF) begin
      errors++; $display("FAIL bp_second_data got=%h/%h exp=ef", out_data[0], out_data[1]);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int l0, l1;
    accept_word(8'h55);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ser_clr_n !== 2'b11 || in_ready !== 2'b00) begin
      errors++; $display("FAIL rst_mid_busy got clr_n=%b rdy=%b exp 11/00", ser_clr_n, in_ready);
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || ser_clr_n[k] !== 1'b0 ||
          ser_data[k] !== 1'b0) begin
        errors++; $display("FAIL rst_mid_ctrl k=%0d got rdy=%b vld=%b clr_n=%b sd=%b exp 1/0/0/0",
                           k, in_ready[k], out_valid[k], ser_clr_n[k], ser_data[k]);
      end
      checks++;
      if ({out_ovf[k], out_err[k], out_data[k]} !== 10'h000) begin
        errors++; $display("FAIL rst_mid_outputs k=%0d got=%b%b_%h exp=00_00", k, out_ovf[k],
                           out_err[k], out_data[k]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 2'b11 || out_valid !== 2'b00) begin
      errors++; $display("FAIL rst_mid_release got rdy=%b vld=%b exp 11/00", in_ready, out_valid);
    end
    accept_word(8'h55);
    wait_done(l0, l1);
    checks++;
    if (out_data[0] !== 8'hAB || out_data[1] !== 8'hAB) begin
      errors++; $display("FAIL rst_mid_retry got=%h/%h exp=ab", out_data[0], out_data[1]);
    end
    release_out();
  endtask

`ifdef SERIAL_NEG_CHECK_EN
  task automatic test_check();
    int l0, l1;
    inj = 1'b1;
    accept_word(8'h06);
    wait_done(l0, l1);
    inj = 1'b0;
    checks++;
    if (out_err !== 2'b11 || out_valid !== 2'b11) begin
      errors++; $display("FAIL chk_inject got err=%b vld=%b exp 11/11", out_err, out_valid);
    end
    release_out();
    accept_word(8'h06);
    wait_done(l0, l1);
    checks++;
    if (out_err !== 2'b00 || out_data[0] !== 8'hFA || out_data[1] !== 8'hFA) begin
      errors++; $display("FAIL chk_clean got err=%b data=%h/%h exp 00 fa", out_err, out_data[0],
                         out_data[1]);
    end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_NEG_CHECK_EN
    test_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_negate_seq.md
Name: serial_negate_seq

Overview:
- Word-level sequencer for the bit-serial two's-complement negator (LSB-first, Mealy: pass bits up to and including the first 1, invert all later bits).
- Accepts a parallel word over a valid/ready handshake and holds the serial unit in clear between words.
- Streams the word LSB-first into the serial unit, reassembles the serial result into a parallel word, and presents it over a valid/ready handshake.
- The serial negator is instantiated outside this block; it connects through the ser_* ports.

Parameters:
- WIDTH, 8: word width in bits; legal range 2 to 64.
- SER_LAT, 0: latency of the serial unit output; 0 = combinational (Mealy) output, 1 = registered output.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  word to negate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  two's complement of the accepted word, modulo 2^WIDTH
- out_ovf  out  1  accepted word was the most-negative value (1 followed by zeros)
- out_err  out  1  self-check mismatch (see Optional Feature)
- ser_clr_n  out  1  active-low clear to the serial unit's reset input
- ser_data  out  1  serial bit to the serial unit
- ser_out  in  1  serial result bit from the serial unit

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high.
- While reset is asserted: state = IDLE; shift and result registers = 0; bit counter = 0; out_ovf = 0; out_err = 0.
- The FSM has four states: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready = 1; out_valid = 0.
  - Accept occurs when in_valid && in_ready at a rising edge. On accept: load shreg <= in_data; counter <= 0; out_ovf <= (in_data == {1'b1, {WIDTH-1{1'b0}}}); go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - ser_data = shreg[0]. At each edge, shreg shifts right by one and the counter increments.
  - When counter == WIDTH-1, go to DONE if SER_LAT = 0, or to DRAIN if SER_LAT = 1.
- DRAIN (SER_LAT = 1 only): lasts exactly one cycle; ser_data = 0; then go to DONE.
- Result capture:
  - Each capture shifts right: res <= {ser_out, res[WIDTH-1:1]}. After WIDTH captures, res[0] holds the result of input bit 0.
  - SER_LAT = 0: capture on every SHIFT edge.
  - SER_LAT = 1: capture on every SHIFT edge except the first, plus the DRAIN edge. This gives exactly WIDTH captures.
- DONE:
  - out_valid = 1; out_data = res, held stable.
  - When out_ready = 1 at an edge, go to IDLE.
  - out_valid stays high under backpressure for any number of cycles.
- ser_clr_n:
  - Decoded from the state register: 1 only in SHIFT and DRAIN, 0 in IDLE and DONE and during reset.
  - This guarantees the serial unit starts every word freshly cleared.
- ser_data = 0 outside SHIFT.
- Latency:
  - With accept at edge E0, out_valid rises after edge E0 + WIDTH + SER_LAT.
  - Next accept is possible one cycle after the result handshake.
  - Throughput: one word per WIDTH + SER_LAT + 2 cycles when out_ready is held at 1.
- Boundary values:
  - Zero input → result 0, out_ovf = 0.
  - Most-negative input → result equals input, out_ovf = 1.
- Simultaneous in_valid during SHIFT, DRAIN or DONE: ignored, because in_ready = 0.
- Reset mid-operation: the word is abandoned immediately. The cycle after reset deasserts: in_ready = 1, out_valid = 0.
- out_ovf and out_err are held from accept through DONE and are valid whenever out_valid = 1.

Optional Feature:
- Macro: SERIAL_NEG_CHECK_EN.
- When defined:
  - At accept, the block also stores ref = (~in_data + 1) truncated to WIDTH bits.
  - On entry to DONE, out_err <= (res != ref).
  - out_err is valid with out_valid and clears on the next accept or on reset.
- When not defined: no reference logic is built, and out_err is tied to 0.

Test Plan (WIDTH = 8, SER_LAT = 0 and 1, bench uses a behavioural model of the serial negator):
- Send in_data = 0x06 with out_ready = 1 → out_data = 0xFA, out_ovf = 0, out_valid asserted 8 + SER_LAT cycles after accept.
- Send 0x00, then 0x01 → out_data = 0x00, then 0xFF; out_ovf = 0 for both; ser_clr_n = 0 between the two words.
- Send 0x80 → out_data = 0x80, out_ovf = 1.
- Send 0x3C and hold out_ready = 0 for 5 cycles in DONE → out_valid and out_data = 0xC4 stable; in_ready = 0; a second in_valid is not accepted until 1 cycle after the result handshake.
- Assert reset for 1 cycle during the 4th SHIFT cycle of 0x55 → all outputs at reset values; ser_clr_n = 0; in_ready = 1 the cycle after release. A following 0x55 then yields 0xAB.
- With SERIAL_NEG_CHECK_EN defined, force the model to flip one output bit for 0x06 → out_err = 1 with out_valid. For a correct 0x06 → out_err = 0.
